// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types and constants for the EX-stage hazard sequencer.
// Holds the sequencer state encoding and register-file index definitions.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    // A source only creates a dependency when it is actually read and names the producer.
    function automatic logic src_dep(input logic used,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
// Carries ID/EX hazard sources in one direction, stall/flush controls and counters in the other.
interface hazard_ctrl_unit_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic [REG_IDX_W-1:0] rs1_id;
    logic [REG_IDX_W-1:0] rs2_id;
    logic                 rs1_used_id;
    logic                 rs2_used_id;
    logic [REG_IDX_W-1:0] rd_ex;
    logic                 mem_read_ex;
    logic                 md_op_ex;
    logic                 branch_taken_ex;

    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 ex_hold;
    logic                 md_busy;
    logic [CNT_W-1:0]     stall_cycles;
    logic [CNT_W-1:0]     flush_events;

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        input  rd_ex, mem_read_ex, md_op_ex, branch_taken_ex,
        output pc_write, if_id_write, if_id_flush, id_ex_flush,
        output ex_hold, md_busy, stall_cycles, flush_events
    );

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        output rd_ex, mem_read_ex, md_op_ex, branch_taken_ex,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush,
        input  ex_hold, md_busy, stall_cycles, flush_events
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Holds at all-ones instead of wrapping so long runs never under-report.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1'b1);

    logic [W-1:0] count_r;

    // Count register: advance on inc until all-ones, then hold.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_r <= '0;
        end else if (inc && (count_r != '1)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush sequencer for the EX stage: load-use bubbles, fixed-latency mul/div
// occupancy and taken-branch squashes, plus stall and flush performance counters.
module hazard_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             arst,
    hazard_ctrl_unit_if.slave hz
);

    localparam int unsigned MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);
    localparam logic [MD_CNT_W-1:0] MD_ONE  = MD_CNT_W'(1'b1);

    hz_state_e           state_r;
    hz_state_e           state_nxt_s;
    logic [MD_CNT_W-1:0] md_cnt_r;
    logic [MD_CNT_W-1:0] md_cnt_nxt_s;

    logic load_use_s;
    logic pc_write_s;
    logic if_id_write_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;
    logic ex_hold_s;
    logic md_busy_s;

    assign load_use_s = hz.mem_read_ex && (hz.rd_ex != REG_X0) &&
                        (src_dep(hz.rs1_used_id, hz.rs1_id, hz.rd_ex) ||
                         src_dep(hz.rs2_used_id, hz.rs2_id, hz.rd_ex));

    // State and mul/div countdown registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r  <= RUN;
            md_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

    // Next-state logic; a branch in EX squashes a mul/div before it can occupy EX.
    always_comb begin
        state_nxt_s  = state_r;
        md_cnt_nxt_s = md_cnt_r;
        case (state_r)
            RUN: begin
                if (hz.branch_taken_ex) begin
                    state_nxt_s = RUN;
                end else if (hz.md_op_ex) begin
                    state_nxt_s  = MD_WAIT;
                    md_cnt_nxt_s = MD_LOAD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MD_WAIT: begin
                if (md_cnt_r != '0) begin
                    md_cnt_nxt_s = md_cnt_r - MD_ONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s  = RUN;
                md_cnt_nxt_s = '0;
            end
        endcase
    end

    // Output decode; in MD_WAIT the frozen ID stage and the held mul/div make branch
    // and load-use inputs irrelevant, and the zero-count cycle releases EX.
    always_comb begin
        pc_write_s    = 1'b1;
        if_id_write_s = 1'b1;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        ex_hold_s     = 1'b0;
        md_busy_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (hz.branch_taken_ex) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else if (hz.md_op_ex) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    ex_hold_s     = 1'b1;
                end else if (load_use_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                end else begin
                    pc_write_s = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy_s = 1'b1;
                if (md_cnt_r != '0) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    ex_hold_s     = 1'b1;
                end else begin
                    pc_write_s = 1'b1;
                end
            end
            default: begin
                pc_write_s = 1'b1;
            end
        endcase
    end

    assign hz.pc_write    = pc_write_s;
    assign hz.if_id_write = if_id_write_s;
    assign hz.if_id_flush = if_id_flush_s;
    assign hz.id_ex_flush = id_ex_flush_s;
    assign hz.ex_hold     = ex_hold_s;
    assign hz.md_busy     = md_busy_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (~pc_write_s),
        .count (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (if_id_flush_s),
        .count (hz.flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: one instance at MD_LATENCY=8/CNT_W=16 and one at
// MD_LATENCY=2/CNT_W=4, sharing stimulus, checked through an expectation queue.
module tb_hazard_ctrl_unit;

    // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, md_busy}
    localparam logic [5:0] C_DEF = 6'b110000;
    localparam logic [5:0] C_LU  = 6'b000100;
    localparam logic [5:0] C_BR  = 6'b111100;
    localparam logic [5:0] C_MD  = 6'b000010;
    localparam logic [5:0] C_MDW = 6'b000011;
    localparam logic [5:0] C_REL = 6'b110001;

    // Input flag order: {rs1_used, rs2_used, mem_read, md_op, branch_taken}
    localparam logic [4:0] F_U1 = 5'b10000;
    localparam logic [4:0] F_U2 = 5'b01000;
    localparam logic [4:0] F_MR = 5'b00100;
    localparam logic [4:0] F_MD = 5'b00010;
    localparam logic [4:0] F_BR = 5'b00001;

    typedef struct {
        string       name;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [4:0]  flags;
        logic [5:0]  ctl;
        logic [15:0] s;
        logic [15:0] f;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk_a;
        logic        chk_b;
        logic [5:0]  ctl_a;
        logic [15:0] s_a;
        logic [15:0] f_a;
        logic [5:0]  ctl_b;
        logic [3:0]  s_b;
        logic [3:0]  f_b;
    } sb_t;

    logic       clk;
    logic       arst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] flg;

    int errors = 0;
    int checks = 0;
    sb_t sbq[$];
    sb_t ent;
    vec_t tbl[12];

    hazard_ctrl_unit_if #(.CNT_W(16)) hif_a ();
    hazard_ctrl_unit_if #(.CNT_W(4))  hif_b ();

    assign hif_a.rs1_id          = rs1;
    assign hif_a.rs2_id          = rs2;
    assign hif_a.rd_ex           = rd;
    assign hif_a.rs1_used_id     = flg[4];
    assign hif_a.rs2_used_id     = flg[3];
    assign hif_a.mem_read_ex     = flg[2];
    assign hif_a.md_op_ex        = flg[1];
    assign hif_a.branch_taken_ex = flg[0];
    assign hif_b.rs1_id          = rs1;
    assign hif_b.rs2_id          = rs2;
    assign hif_b.rd_ex           = rd;
    assign hif_b.rs1_used_id     = flg[4];
    assign hif_b.rs2_used_id     = flg[3];
    assign hif_b.mem_read_ex     = flg[2];
    assign hif_b.md_op_ex        = flg[1];
    assign hif_b.branch_taken_ex = flg[0];

    hazard_ctrl_unit #(.MD_LATENCY(8), .CNT_W(16)) dut_a (
        .clk  (clk),
        .arst (arst),
        .hz   (hif_a.slave)
    );

    hazard_ctrl_unit #(.MD_LATENCY(2), .CNT_W(4)) dut_b (
        .clk  (clk),
        .arst (arst),
        .hz   (hif_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic rst_v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rdv, input logic [4:0] fl);
        @(posedge clk);
        #1;
        arst = rst_v;
        rs1  = r1;
        rs2  = r2;
        rd   = rdv;
        flg  = fl;
    endtask

    task automatic expect_ab(input string nm, input logic ca, input logic [5:0] cta,
                             input logic [15:0] sa, input logic [15:0] fa,
                             input logic cb, input logic [5:0] ctb,
                             input logic [3:0] sbv, input logic [3:0] fbv);
        sb_t e;
        e.name  = nm;
        e.chk_a = ca;
        e.ctl_a = cta;
        e.s_a   = sa;
        e.f_a   = fa;
        e.chk_b = cb;
        e.ctl_b = ctb;
        e.s_b   = sbv;
        e.f_b   = fbv;
        sbq.push_back(e);
    endtask

    // Monitor: compare queued expectations on the falling edge, mid-cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            if (ent.chk_a) begin
                checks++;
                if ({hif_a.pc_write, hif_a.if_id_write, hif_a.if_id_flush, hif_a.id_ex_flush,
                     hif_a.ex_hold, hif_a.md_busy} !== ent.ctl_a ||
                    hif_a.stall_cycles !== ent.s_a || hif_a.flush_events !== ent.f_a) begin
                    errors++;
                    $display("FAIL %s (A): got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                             ent.name,
                             {hif_a.pc_write, hif_a.if_id_write, hif_a.if_id_flush,
                              hif_a.id_ex_flush, hif_a.ex_hold, hif_a.md_busy},
                             hif_a.stall_cycles, hif_a.flush_events, ent.ctl_a, ent.s_a, ent.f_a);
                end
            end
            if (ent.chk_b) begin
                checks++;
                if ({hif_b.pc_write, hif_b.if_id_write, hif_b.if_id_flush, hif_b.id_ex_flush,
                     hif_b.ex_hold, hif_b.md_busy} !== ent.ctl_b ||
                    hif_b.stall_cycles !== ent.s_b || hif_b.flush_events !== ent.f_b) begin
                    errors++;
                    $display("FAIL %s (B): got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                             ent.name,
                             {hif_b.pc_write, hif_b.if_id_write, hif_b.if_id_flush,
                              hif_b.id_ex_flush, hif_b.ex_hold, hif_b.md_busy},
                             hif_b.stall_cycles, hif_b.flush_events, ent.ctl_b, ent.s_b, ent.f_b);
                end
            end
        end
    end

    initial begin
        arst = 1'b1;
        rs1  = 5'd0;
        rs2  = 5'd0;
        rd   = 5'd0;
        flg  = 5'b00000;

        tbl[0]  = '{"idle0",       5'd0, 5'd0, 5'd0, 5'b00000,          C_DEF, 16'd0, 16'd0};
        tbl[1]  = '{"lu_rs2",      5'd0, 5'd5, 5'd5, F_U2 | F_MR,       C_LU,  16'd0, 16'd0};
        tbl[2]  = '{"after_lu",    5'd0, 5'd0, 5'd0, 5'b00000,          C_DEF, 16'd1, 16'd0};
        tbl[3]  = '{"x0_filter",   5'd0, 5'd0, 5'd0, F_U1 | F_MR,       C_DEF, 16'd1, 16'd0};
        tbl[4]  = '{"unused_src",  5'd7, 5'd0, 5'd7, F_MR,              C_DEF, 16'd1, 16'd0};
        tbl[5]  = '{"lu_rs1",      5'd7, 5'd0, 5'd7, F_U1 | F_MR,       C_LU,  16'd1, 16'd0};
        tbl[6]  = '{"no_match",    5'd6, 5'd8, 5'd7, F_U1 | F_U2 | F_MR, C_DEF, 16'd2, 16'd0};
        tbl[7]  = '{"no_load",     5'd7, 5'd0, 5'd7, F_U1,              C_DEF, 16'd2, 16'd0};
        tbl[8]  = '{"br_over_lu",  5'd0, 5'd5, 5'd5, F_U2 | F_MR | F_BR, C_BR,  16'd2, 16'd0};
        tbl[9]  = '{"after_br",    5'd0, 5'd0, 5'd0, 5'b00000,          C_DEF, 16'd2, 16'd1};
        tbl[10] = '{"br_over_md",  5'd0, 5'd0, 5'd0, F_MD | F_BR,       C_BR,  16'd2, 16'd1};
        tbl[11] = '{"no_md_entry", 5'd0, 5'd0, 5'd0, 5'b00000,          C_DEF, 16'd2, 16'd2};

        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'b00000);
        expect_ab("reset", 1'b1, C_DEF, 16'd0, 16'd0, 1'b1, C_DEF, 4'd0, 4'd0);

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].flags);
            expect_ab(tbl[i].name, 1'b1, tbl[i].ctl, tbl[i].s, tbl[i].f,
                      1'b1, tbl[i].ctl, tbl[i].s[3:0], tbl[i].f[3:0]);
        end

        // Mul/div on A with a simultaneous load: md wins, then seven stall cycles.
        drive(1'b0, 5'd5, 5'd0, 5'd5, F_MD | F_MR | F_U1);
        expect_ab("md_entry", 1'b1, C_MD, 16'd2, 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 5'd5, 5'd0, 5'd5, (k == 2) ? (F_MD | F_BR) : ((k == 3) ? (F_MD | F_MR | F_U1) : F_MD));
            expect_ab("md_wait", 1'b1, C_MDW, 16'(2 + k), 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
        expect_ab("md_release", 1'b1, C_REL, 16'd9, 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);

        // Back-to-back op re-enters MD_WAIT straight after the release cycle.
        drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
        expect_ab("md2_entry", 1'b1, C_MD, 16'd9, 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
            expect_ab("md2_wait", 1'b1, C_MDW, 16'(9 + k), 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
        expect_ab("md2_release", 1'b1, C_REL, 16'd16, 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'b00000);
        expect_ab("md2_idle", 1'b1, C_DEF, 16'd16, 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);

        // Reset in the middle of MD_WAIT takes effect before the next clock edge.
        drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
        expect_ab("md3_entry", 1'b1, C_MD, 16'd16, 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        for (int k = 1; k <= 2; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
            expect_ab("md3_wait", 1'b1, C_MDW, 16'(16 + k), 16'd2, 1'b0, C_DEF, 4'd0, 4'd0);
        end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'b00000);
        expect_ab("reset_mid_md", 1'b1, C_DEF, 16'd0, 16'd0, 1'b1, C_DEF, 4'd0, 4'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'b00000);
        expect_ab("post_reset_idle", 1'b1, C_DEF, 16'd0, 16'd0, 1'b1, C_DEF, 4'd0, 4'd0);

        // B: MD_LATENCY=2 gives a single stall, then the release cycle.
        drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
        expect_ab("b_md_entry", 1'b0, C_DEF, 16'd0, 16'd0, 1'b1, C_MD, 4'd0, 4'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, F_MD);
        expect_ab("b_md_release", 1'b0, C_DEF, 16'd0, 16'd0, 1'b1, C_REL, 4'd1, 4'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'b00000);
        expect_ab("b_md_idle", 1'b0, C_DEF, 16'd0, 16'd0, 1'b1, C_DEF, 4'd1, 4'd0);

        // B: 20 consecutive load-use stalls saturate the 4-bit stall counter.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd3, 5'd0, 5'd3, F_U1 | F_MR);
            expect_ab("b_sat_lu", 1'b0, C_DEF, 16'd0, 16'd0, 1'b1, C_LU,
                      ((1 + i) > 15) ? 4'd15 : 4'(1 + i), 4'd0);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'b00000);
        expect_ab("b_sat_hold", 1'b0, C_DEF, 16'd0, 16'd0, 1'b1, C_DEF, 4'd15, 4'd0);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

- Sequences pipeline stalls and flushes around the EX-stage forwarding datapath of the 5-stage RISC-V core.
- Handles three cases: load-use hazards that forwarding cannot cover, a fixed-latency multi-cycle mul/div op that occupies EX, and taken-branch squashes.
- Drives the PC and IF/ID write enables, the IF/ID and ID/EX flushes, and the EX hold.
- Keeps two saturating performance counters.

## Interface
Parameters:
- MD_LATENCY, 8, total cycles a mul/div op occupies EX; legal range >= 2
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- arst  in  1  asynchronous active-high reset
- rs1_id  in  5  source register 1 of the ID instruction
- rs2_id  in  5  source register 2 of the ID instruction
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- rd_ex  in  5  destination register of the EX instruction
- mem_read_ex  in  1  EX instruction is a load
- md_op_ex  in  1  EX instruction is a multi-cycle mul/div
- branch_taken_ex  in  1  EX resolved a taken branch or jump
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register write enable
- if_id_flush  out  1  IF/ID register loads a bubble
- id_ex_flush  out  1  ID/EX register loads a bubble
- ex_hold  out  1  ID/EX holds its value; EX/MEM loads a bubble
- md_busy  out  1  high while in MD_WAIT
- stall_cycles  out  CNT_W  count of cycles with pc_write=0
- flush_events  out  CNT_W  count of cycles with if_id_flush=1

## Operation
- **FSM states:** RUN and MD_WAIT, plus a down-counter md_cnt of width clog2(MD_LATENCY).
- **Default outputs:** pc_write=1, if_id_write=1, all other outputs 0.
- **RUN priority 1, branch_taken_ex=1:**
  - if_id_flush=1, id_ex_flush=1, pc_write=1.
  - md_op_ex and the load-use check are ignored in this cycle.
- **RUN priority 2, md_op_ex=1:**
  - pc_write=0, if_id_write=0, ex_hold=1.
  - Next state MD_WAIT; md_cnt is loaded with MD_LATENCY-2.
- **RUN priority 3, load-use:**
  - Condition: mem_read_ex=1 and rd_ex!=0 and ((rs1_used_id and rs1_id==rd_ex) or (rs2_used_id and rs2_id==rd_ex)).
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly this cycle. State stays RUN.
  - The following cycle is resolved by the MEM-to-EX forwarding path.
- **MD_WAIT with md_cnt!=0:**
  - pc_write=0, if_id_write=0, ex_hold=1.
  - md_cnt decrements.
- **MD_WAIT with md_cnt==0 (release cycle):**
  - Default outputs.
  - Next state RUN.
  - md_op_ex is ignored in this cycle (same instruction leaving EX).
- **Inputs ignored in MD_WAIT:**
  - branch_taken_ex (EX holds the mul/div op, which cannot branch).
  - The load-use check (ID is frozen; it is re-evaluated in RUN).
- **Occupancy:** a mul/div op occupies EX for exactly MD_LATENCY cycles; the front end stalls MD_LATENCY-1 of them.
- **Counters:**
  - stall_cycles increments in every cycle with pc_write=0.
  - flush_events increments in every cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- **Mutually exclusive inputs:** mem_read_ex and md_op_ex are never both high (one EX instruction). If they are, md_op_ex wins.

## Timing
- Control outputs are combinational from (state, md_cnt, inputs) and act in the same cycle the hazard is visible. No extra latency.
- md_busy is a pure state decode, glitch-free with respect to the inputs.
- **Reset values:** state=RUN, md_cnt=0, stall_cycles=0, flush_events=0.
- **Outputs under reset:** with inputs low, pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, ex_hold=0, md_busy=0.
- **Reset mid-MD_WAIT:**
  - Returns to RUN asynchronously; ex_hold and md_busy drop immediately.
  - No release cycle is generated.
- **MD_LATENCY=2:** entry cycle loads md_cnt=0; the next cycle is the release cycle (one stall).
- **Back-to-back mul/div:**
  - The second op enters EX in the cycle after the release cycle, re-entering MD_WAIT from RUN.
  - No idle cycle is required.
- **Simultaneous branch and load-use in RUN:** branch wins; only the flush is issued; the stall counter does not increment.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MD_WAIT)
  - the register-index width constant (5)
  - the constant for register x0
- Sub-module sat_counter (parameter W; ports clk, arst, inc, count) is instantiated twice for the performance counters.
- FSM, md_cnt and output decode live in hazard_ctrl_unit.

## Test plan
1. **Load-use on rs2:** mem_read_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_cycles 0->1.
2. **x0 / unused-source filter:** rd_ex=0 with rs1_id=0, rs1_used_id=1, mem_read_ex=1 -> no stall. Then rd_ex=7, rs1_id=7, rs1_used_id=0 -> no stall.
3. **Mul/div with MD_LATENCY=8:** md_op_ex pulse at cycle T -> ex_hold=1 and pc_write=0 for cycles T..T+6, release at T+7, md_busy=1 for T+1..T+7; stall_cycles=7.
4. **Branch priority:** branch_taken_ex=1 together with a load-use condition -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_events=1, stall_cycles unchanged.
5. **Reset mid-MD_WAIT:** arst asserted at T+3 of scenario 3 -> md_busy, ex_hold and the counters go to 0 immediately. After release, an idle cycle gives pc_write=1.
6. **Saturation:** CNT_W=4, drive 20 consecutive load-use stalls -> stall_cycles holds at 15.
